// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: reset defaults, FSM state encodings and
// small address helpers used by both the fetch unit and its next-PC mux.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam int unsigned DEFAULT_MEM_WORDS = 1024;
    localparam logic [31:0] WORD_BYTES        = 32'd4;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] byte_addr);
        return byte_addr & ~32'h0000_0003;
    endfunction

    // Byte address -> word index into a memory of 'words' entries (wraps).
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned words);
        return (byte_addr >> 2) % words;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: memory address/data, decode handshake (stall/redirect)
// and the tagged instruction handed to decode.
interface instruction_fetch_unit_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] instructionAddress;
    logic [31:0] instructionCode;
    logic [31:0] ifInstr;
    logic [31:0] ifPc;
    logic [31:0] ifPcPlus4;
    logic        ifValid;
    logic        alignErr;

    // The fetch unit itself.
    modport master (
        input  stall, redirect, redirectTarget, instructionCode,
        output instructionAddress, ifInstr, ifPc, ifPcPlus4, ifValid, alignErr
    );

    // The surrounding pipeline: instruction memory plus decode.
    modport slave (
        output stall, redirect, redirectTarget, instructionCode,
        input  instructionAddress, ifInstr, ifPc, ifPcPlus4, ifValid, alignErr
    );

endinterface

// File: rtl/instruction_fetch_unit_next_pc.sv
// Combinational fetch-address selection and next-PC arithmetic.
// Priority: reset, redirect, replay on stall, sequential pc.
module fetch_next_pc
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic         reset_n,
    input  logic         redirect,
    input  logic         stall,
    input  logic [31:0]  redirect_target,
    input  fetch_state_t state,
    input  logic [31:0]  pc,
    input  logic [31:0]  fetch_pc,
    output logic [31:0]  fetched,
    output logic [31:0]  next_pc,
    output logic [31:0]  instruction_address,
    output logic [31:0]  fetch_pc_plus4,
    output logic         misaligned
);

    logic replay;

    // Pick the byte address fetched this cycle and the pc that follows it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        fetched = pc;
        replay  = 1'b0;
        if (!reset_n) begin
            fetched = RESET_PC;
        end else if (redirect) begin
            fetched = align_word(redirect_target);
        end else if (state != FETCH_BOOT && stall) begin
            // Re-read the word decode is still holding; pc must not advance.
            fetched = fetch_pc;
            replay  = 1'b1;
        end
        next_pc = replay ? pc : fetched + WORD_BYTES;
    end

    assign instruction_address = word_index(fetched, MEM_WORDS);
    assign fetch_pc_plus4      = fetch_pc + WORD_BYTES;
    assign misaligned          = redirect && (redirect_target[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the sync-read instruction
// memory and tags the returned word with its PC and a valid bit for decode.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    instruction_fetch_unit_if.master bus
);

    logic [31:0]  pc;
    logic [31:0]  fetch_pc;
    fetch_state_t state;
    logic         align_err;

    logic [31:0]  fetched;
    logic [31:0]  next_pc;
    logic [31:0]  fetch_pc_plus4;
    logic [31:0]  instruction_address;
    logic         misaligned;

    fetch_next_pc #(
        .RESET_PC  (RESET_PC),
        .MEM_WORDS (MEM_WORDS)
    ) u_next_pc (
        .reset_n             (reset_n),
        .redirect            (bus.redirect),
        .stall               (bus.stall),
        .redirect_target     (bus.redirectTarget),
        .state               (state),
        .pc                  (pc),
        .fetch_pc            (fetch_pc),
        .fetched             (fetched),
        .next_pc             (next_pc),
        .instruction_address (instruction_address),
        .fetch_pc_plus4      (fetch_pc_plus4),
        .misaligned          (misaligned)
    );

    // PC, fetch-tag, FSM and sticky alignment-error registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
        if (!reset_n) begin
            pc        <= RESET_PC;
            fetch_pc  <= RESET_PC;
            state     <= FETCH_BOOT;
            align_err <= 1'b0;
        end else begin
            fetch_pc <= fetched;
            pc       <= next_pc;
            if (misaligned) begin
                align_err <= 1'b1;
            end
            case (state)
                FETCH_BOOT: state <= FETCH_RUN;
                FETCH_RUN,
                FETCH_HOLD: state <= (!bus.redirect && bus.stall) ? FETCH_HOLD : FETCH_RUN;
                default:    state <= FETCH_BOOT;
            endcase
        end
    end

    assign bus.instructionAddress = instruction_address;
    assign bus.ifInstr            = bus.instructionCode;
    assign bus.ifPc               = fetch_pc;
    assign bus.ifPcPlus4          = fetch_pc_plus4;
    assign bus.ifValid            = (state != FETCH_BOOT);
    assign bus.alignErr           = align_err;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: sync-read instruction memory holding
// A000_0000 + index, directed scenarios followed by a randomized run, all
// checked against a fetch-stream reference model.
module tb_instruction_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned MEM_WORDS = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Instruction memory, one clock read latency; out-of-range reads give X.
    logic [31:0] imem [MEM_WORDS];
    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) imem[i] = 32'hA000_0000 + 32'(i);
    end
    always @(posedge clk) bus.instructionCode <= imem[bus.instructionAddress];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: what decode should be seeing, and where the
    // sequential stream continues.
    bit          m_valid = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_next;
    bit          m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, check the memory address, clock, then check
    // the tagged instruction against the model.
    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        logic [31:0] sel;
        bit          replay;
        reset_n            = r;
        bus.stall          = s;
        bus.redirect       = d;
        bus.redirectTarget = t;
        replay = 1'b0;
        if (!r)                   sel = RESET_PC;
        else if (d)               sel = t & ~32'h3;
        else if (s && m_valid)    begin sel = m_pc; replay = 1'b1; end
        else                      sel = m_next;
        #1;
        check("instructionAddress", bus.instructionAddress, (sel >> 2) % MEM_WORDS);
        @(posedge clk);
        if (!r) begin
            m_valid = 1'b0;
            m_pc    = RESET_PC;
            m_next  = RESET_PC;
            m_err   = 1'b0;
        end else begin
            m_valid = 1'b1;
            m_pc    = sel;
            if (!replay) m_next = sel + 32'd4;
            if (d && t[1:0] != 2'b00) m_err = 1'b1;
        end
        @(negedge clk);
        check("ifValid", 32'(bus.ifValid), 32'(m_valid));
        check("ifPc", bus.ifPc, m_pc);
        check("ifPcPlus4", bus.ifPcPlus4, m_pc + 32'd4);
        check("alignErr", 32'(bus.alignErr), 32'(m_err));
        if (m_valid) check("ifInstr", bus.ifInstr, 32'hA000_0000 + ((m_pc >> 2) % MEM_WORDS));
    endtask

    initial begin
        bus.stall          = 1'b0;
        bus.redirect       = 1'b0;
        bus.redirectTarget = 32'h0;

        // Reset for three clocks: nothing valid, PC parked at RESET_PC.
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("reset_valid", 32'(bus.ifValid), 32'h0);

        // Release: boot cycle, then sequential stream from word 0.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("first_pc", bus.ifPc, 32'h0);
        check("first_instr", bus.ifInstr, 32'hA000_0000);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("second_instr", bus.ifInstr, 32'hA000_0001);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // Stall three clocks at ifPc=8: the same word is replayed.
        repeat (3) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            check("stall_pc", bus.ifPc, 32'h8);
            check("stall_instr", bus.ifInstr, 32'hA000_0002);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("unstall_pc", bus.ifPc, 32'hC);
        check("unstall_instr", bus.ifInstr, 32'hA000_0003);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect to 0x40 from ifPc=0x10.
        step(1'b1, 1'b0, 1'b1, 32'h40);
        check("redir_pc", bus.ifPc, 32'h40);
        check("redir_instr", bus.ifInstr, 32'hA000_0010);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("redir_next_instr", bus.ifInstr, 32'hA000_0011);

        // Redirect and stall together: redirect wins, no replay afterwards.
        step(1'b1, 1'b1, 1'b1, 32'h20);
        check("redir_stall_pc", bus.ifPc, 32'h20);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("after_redir_stall_pc", bus.ifPc, 32'h24);

        // Misaligned target: sticky error, target forced aligned.
        step(1'b1, 1'b0, 1'b1, 32'h42);
        check("misalign_pc", bus.ifPc, 32'h40);
        check("misalign_err", 32'(bus.alignErr), 32'h1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h100);
        check("sticky_err", 32'(bus.alignErr), 32'h1);

        // PC wrap at the top of the address space, word index wrap in memory.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_plus4", bus.ifPcPlus4, 32'h0);
        check("wrap_instr", bus.ifInstr, 32'hA000_003F);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrapped_pc", bus.ifPc, 32'h0);

        // Reset while holding at 0x30, with a redirect also pending.
        step(1'b1, 1'b0, 1'b1, 32'h30);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h8);
        check("reset_hold_valid", 32'(bus.ifValid), 32'h0);
        check("reset_hold_pc", bus.ifPc, RESET_PC);
        check("reset_hold_err", 32'(bus.alignErr), 32'h0);

        // Boot with stall asserted: stall is ignored in the boot cycle.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("boot_stall_pc", bus.ifPc, RESET_PC);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic        r, s, d;
            logic [31:0] t;
            r = ($urandom_range(0, 49) != 0);
            s = ($urandom_range(0, 9) < 3);
            d = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
            step(r, s, d, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
